// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry layout.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_4;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of {instr, pc_4} entries with clear; head is read
// combinationally from the registered storage array.
module prefetch_fifo import cpu_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [2*XLEN-1:0]            wdata,
  output logic [2*XLEN-1:0]            rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between the I-memory port and IF/ID.
// Define PREFETCH_BYPASS_EN for a zero-latency response-to-output path when the queue is empty.
module instr_prefetch_queue import cpu_pkg::*; #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        deq_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_4
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthSum = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   enq_pc_q, enq_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d, outstanding_after_resp;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic [2*XLEN-1:0] fifo_rdata;
  fetch_entry_t      head, wentry, out_entry;
  logic              req_fire, resp_keep, push, pop;

  assign mem_req_valid = !rst && !redirect_valid &&
                         (({1'b0, fifo_count} + {1'b0, outstanding_q}) < DepthSum);
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response is kept only when no stale responses remain and no flush is in progress.
  assign resp_keep = mem_resp_valid && (drop_q == '0) && !redirect_valid;
  assign head      = fetch_entry_t'(fifo_rdata);
  assign wentry    = '{instr: mem_resp_data, pc_4: enq_pc_q + PC_STEP};
  assign pop       = !fifo_empty && deq_ready && !redirect_valid;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && (drop_q == '0) && mem_resp_valid;
  assign push      = resp_keep && !(bypass && deq_ready);
  assign out_valid = !fifo_empty || bypass;
  assign out_entry = fifo_empty ? wentry : head;
`else
  assign push      = resp_keep;
  assign out_valid = !fifo_empty;
  assign out_entry = head;
`endif

  assign out_instr = out_valid ? out_entry.instr : INSTR_NOP;
  assign out_pc_4  = out_valid ? out_entry.pc_4  : '0;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    outstanding_after_resp = outstanding_q - CntW'(mem_resp_valid);
    outstanding_d          = outstanding_after_resp + CntW'(req_fire);
    fetch_pc_d             = fetch_pc_q;
    enq_pc_d               = enq_pc_q;
    drop_d                 = drop_q - CntW'(mem_resp_valid && (drop_q != '0));
    if (redirect_valid) begin
      // Everything still in flight belongs to the abandoned path.
      fetch_pc_d = redirect_pc;
      enq_pc_d   = redirect_pc;
      drop_d     = outstanding_after_resp;
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + PC_STEP;
      if (resp_keep) enq_pc_d   = enq_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      enq_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      enq_pc_q      <= enq_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!mem_resp_valid || (outstanding_q != '0));
      assert (!redirect_valid || (redirect_pc[1:0] == 2'b00));
      assert (!push || !fifo_full || pop);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a bench-side variable-latency memory model.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_4;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc_4       (out_pc_4)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        deq;
    logic        rv;
    logic [31:0] ra;
    logic        ov;
    logic [31:0] pc4;
  } vec_t;

  pend_t       pend[$];
  vec_t        vecs[15];
  int          cyc, lat, nacc;
  int          checks = 0;
  int          failures = 0;
  logic        s_rv, s_ov;
  logic [31:0] s_ra, s_oi, s_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: memory model drives its response, outputs sampled at the falling edge.
  task automatic cycle();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = ~pend[0].addr;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
    end
    @(negedge clk);
    s_rv = mem_req_valid;
    s_ra = mem_req_addr;
    s_ov = out_valid;
    s_oi = out_instr;
    s_op = out_pc_4;
    if (mem_resp_valid) void'(pend.pop_front());
    if (mem_req_valid && mem_req_ready) begin
      pend.push_back('{addr: mem_req_addr, due: cyc + lat});
      nacc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    deq_ready      = 1'b0;
    mem_req_ready  = 1'b1;
    lat            = 1;
    pend.delete();
    cycle();
    cycle();
    rst  = 1'b0;
    cyc  = 0;
    nacc = 0;
  endtask

  initial begin
    vecs = '{
      '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00},
      '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00},
      '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04},
      '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08},
      '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C},
      '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10},
      '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14},
      '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h14},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h14},
      '{1'b1, 1'b0, 32'h00, 1'b1, 32'h14},
      '{1'b1, 1'b1, 32'h20, 1'b1, 32'h18},
      '{1'b1, 1'b1, 32'h24, 1'b1, 32'h1C},
      '{1'b1, 1'b1, 32'h28, 1'b1, 32'h20},
      '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h24}
    };
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    cyc = 0;
    nacc = 0;

    do_reset();
    check("reset.req_valid", 32'(s_rv), 32'd0);
    check("reset.out_valid", 32'(s_ov), 32'd0);
    check("reset.out_instr", s_oi, 32'h0);
    check("reset.out_pc_4", s_op, 32'h0);

    // Streaming with single-cycle memory, then a short stall and release.
    for (int i = 0; i < 15; i++) begin
      deq_ready = vecs[i].deq;
      cycle();
      check($sformatf("vec%0d.req_valid", i), 32'(s_rv), 32'(vecs[i].rv));
      if (vecs[i].rv) check($sformatf("vec%0d.req_addr", i), s_ra, vecs[i].ra);
      check($sformatf("vec%0d.out_valid", i), 32'(s_ov), 32'(vecs[i].ov));
      check($sformatf("vec%0d.out_pc_4", i), s_op, vecs[i].pc4);
      check($sformatf("vec%0d.out_instr", i), s_oi,
            vecs[i].ov ? ~(vecs[i].pc4 - 32'd4) : 32'h0);
    end

    // Stall from the start: queue fills to DEPTH, head held, then drains in order.
    do_reset();
    deq_ready = 1'b0;
    repeat (10) cycle();
    check("stall.accepted", 32'(nacc), 32'd4);
    check("stall.req_valid", 32'(s_rv), 32'd0);
    check("stall.out_valid", 32'(s_ov), 32'd1);
    check("stall.out_pc_4", s_op, 32'h4);
    check("stall.out_instr", s_oi, ~32'h0);
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("drain%0d.out_pc_4", k), s_op, 32'(4 * (k + 1)));
      check($sformatf("drain%0d.out_instr", k), s_oi, ~(32'(4 * k)));
    end

    // Latency-3 memory, redirect with two requests in flight.
    do_reset();
    lat = 3;
    deq_ready = 1'b1;
    cycle();
    cycle();
    check("redir3.accepted", 32'(nacc), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    check("redir3.req_valid_in_redirect", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k == 0) begin
        check("redir3.req_valid_next", 32'(s_rv), 32'd1);
        check("redir3.req_addr_next", s_ra, 32'h100);
      end
      if (k < 4) begin
        check($sformatf("redir3.out_valid%0d", k), 32'(s_ov), 32'd0);
      end else begin
        check("redir3.out_valid", 32'(s_ov), 32'd1);
        check("redir3.out_pc_4", s_op, 32'h104);
        check("redir3.out_instr", s_oi, ~32'h100);
      end
    end

    // Redirect coinciding with a response and deq_ready.
    do_reset();
    deq_ready = 1'b1;
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    check("redir1.req_valid_in_redirect", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    cycle();
    check("redir1.req_valid_next", 32'(s_rv), 32'd1);
    check("redir1.req_addr_next", s_ra, 32'h100);
    check("redir1.out_valid_next", 32'(s_ov), 32'd0);
    cycle();
    cycle();
    check("redir1.out_valid", 32'(s_ov), 32'd1);
    check("redir1.out_pc_4", s_op, 32'h104);
    check("redir1.out_instr", s_oi, ~32'h100);

    // Back-pressure on the request port.
    do_reset();
    deq_ready     = 1'b1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("bp%0d.req_valid", k), 32'(s_rv), 32'd1);
      check($sformatf("bp%0d.req_addr", k), s_ra, 32'h0);
    end
    mem_req_ready = 1'b1;
    cycle();
    check("bp.accept_addr", s_ra, 32'h0);
    check("bp.accepted", 32'(nacc), 32'd1);
    cycle();
    check("bp.next_addr", s_ra, 32'h4);
    cycle();
    check("bp.next_addr2", s_ra, 32'h8);

    // Fetch PC wrap at the top of the address space.
    do_reset();
    deq_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    check("wrap.req_valid_in_redirect", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    cycle();
    check("wrap.req_valid", 32'(s_rv), 32'd1);
    check("wrap.req_addr_top", s_ra, 32'hFFFF_FFFC);
    cycle();
    check("wrap.req_addr_wrapped", s_ra, 32'h0);
    cycle();
    check("wrap.out_valid", 32'(s_ov), 32'd1);
    check("wrap.out_pc_4", s_op, 32'h0);
    check("wrap.out_instr", s_oi, 32'h0000_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
